// File: rtl/store_trace_monitor_pkg.sv
// Shared types and defaults for the store trace monitor.
// Holds the trace entry layout, monitor states and completion defaults.
package riscv_trace_pkg;

  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0100;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] tstamp;
  } trace_entry_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } mon_state_t;

endpackage

// File: rtl/store_trace_monitor_if.sv
// Trace drain stream: head entry plus valid/ready handshake.
// master = monitor side, slave = consumer side.
interface store_trace_monitor_if #(
  parameter int XLEN = 32,
  parameter int TS_W = 32
);
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_addr;
  logic [XLEN-1:0] trace_data;
  logic [TS_W-1:0] trace_time;

  modport master (
    output trace_valid,
    input  trace_ready,
    output trace_addr,
    output trace_data,
    output trace_time
  );

  modport slave (
    input  trace_valid,
    output trace_ready,
    input  trace_addr,
    input  trace_data,
    input  trace_time
  );
endinterface

// File: rtl/store_trace_monitor_fifo.sv
// Synchronous FIFO for trace entries, extra pointer bit for full/empty.
// Head reads as zero while empty so idle outputs are clean.
module trace_fifo
  import riscv_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;
  entry_t      mem [DEPTH];

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the same cycle, so push is allowed when full.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_trace_monitor.sv
// Store trace monitor: timestamps core stores, detects tohost completion.
// Optional address window capture with STORE_TRACE_FILTER_EN.
module store_trace_monitor
  import riscv_trace_pkg::*;
#(
  parameter int            XLEN           = 32,
  parameter int            DEPTH          = 16,
  parameter int            TS_W           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(DEF_TOHOST_ADDR),
  parameter int            TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [XLEN-1:0] FILTER_LO    = '0,
  parameter logic [XLEN-1:0] FILTER_HI    = XLEN'(32'h0000_00FF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_write,
  input  logic [XLEN-1:0] data_addr_m,
  input  logic [XLEN-1:0] write_data_m,
  store_trace_monitor_if.master tr,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic            overflow,
  output logic [7:0]      drop_count
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [TS_W-1:0] tstamp;
  } entry_t;

  localparam logic [TS_W-1:0] WD_LAST = TS_W'(TIMEOUT_CYCLES - 1);

  mon_state_t      state;
  mon_state_t      state_d;
  logic [TS_W-1:0] cnt;
  logic            run;
  logic            hit_tohost;
  logic            in_win;
  logic            push_req;
  logic            drop;
  logic            full;
  logic            empty;
  entry_t          din;
  entry_t          head;

  assign run        = state == S_RUN;
  assign hit_tohost = run & mem_write & (data_addr_m == TOHOST_ADDR);

`ifdef STORE_TRACE_FILTER_EN
  // Unsigned offset test covers LO..HI without a constant compare.
  assign in_win = (data_addr_m - FILTER_LO) <= (FILTER_HI - FILTER_LO);
`else
  logic unused_filter;
  assign in_win        = 1'b1;
  assign unused_filter = ^{FILTER_LO, FILTER_HI};
`endif

  assign push_req = run & mem_write & (in_win | hit_tohost);
  assign drop     = push_req & full & ~tr.trace_ready;

  assign din = '{addr: data_addr_m, data: write_data_m, tstamp: cnt};

  trace_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_req),
    .pop  (tr.trace_ready),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (hit_tohost)
          state_d = (write_data_m == XLEN'(1)) ? S_PASS : S_FAIL;
        else if (cnt == WD_LAST)
          state_d = S_TIMEOUT;
      end
      default: state_d = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start)
        cnt <= '0;
      else if (run && cnt != '1)
        cnt <= cnt + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign done    = (state == S_PASS) | (state == S_FAIL) |
                   (state == S_TIMEOUT);
  assign pass    = state == S_PASS;
  assign timeout = state == S_TIMEOUT;

  assign tr.trace_valid = ~empty;
  assign tr.trace_addr  = head.addr;
  assign tr.trace_data  = head.data;
  assign tr.trace_time  = head.tstamp;

endmodule

// File: doc/store_trace_monitor.md
Name: store_trace_monitor

Overview:
- Synthesizable on-chip monitor for the pipelined RV32I core's data-memory write port (mem_write, data_addr_m, write_data_m).
- Timestamps every captured store and buffers it in a parametrised FIFO, drained through a valid/ready interface.
- Detects test completion on a write to a "tohost" address and reports pass or fail.
- A watchdog declares timeout if no completion write arrives within a cycle budget.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- TS_W, 32, timestamp/cycle-counter width.
- TOHOST_ADDR, 32'h0000_0100, completion address.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN cycles.
- FILTER_LO, 32'h0000_0000, capture window low bound, inclusive (FILTER_EN only).
- FILTER_HI, 32'h0000_00FF, capture window high bound, inclusive (FILTER_EN only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; IDLE->RUN.
- mem_write  in  1  store strobe from the core (memory stage).
- data_addr_m  in  XLEN  store address.
- write_data_m  in  XLEN  store data.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts the head.
- trace_addr  out  XLEN  head address.
- trace_data  out  XLEN  head data.
- trace_time  out  TS_W  head timestamp.
- done  out  1  in PASS, FAIL or TIMEOUT.
- pass  out  1  in PASS.
- timeout  out  1  in TIMEOUT.
- overflow  out  1  sticky; at least one store dropped.
- drop_count  out  8  saturating count of dropped stores.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; FIFO empty; cycle counter=0; all outputs 0; trace_* outputs 0.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - IDLE->RUN on start.
  - start is ignored in every other state; only reset leaves a terminal state.
- Cycle counter:
  - Clears on IDLE->RUN.
  - Increments every RUN cycle and saturates at all-ones.
  - Frozen in terminal states.
- Capture:
  - In RUN, every cycle with mem_write=1 pushes {data_addr_m, write_data_m, counter} to the FIFO.
  - Push is registered: the entry is visible at trace_valid on the next cycle.
  - There is no capture in IDLE or terminal states.
- Completion:
  - In RUN, mem_write=1 with data_addr_m==TOHOST_ADDR moves to PASS if write_data_m==1, otherwise to FAIL.
  - The tohost store is itself captured (subject to FIFO space).
- Watchdog:
  - In RUN, when counter reaches TIMEOUT_CYCLES-1 without a tohost write, go to TIMEOUT on the next edge.
  - A tohost write in that same cycle takes priority: PASS or FAIL.
- FIFO drain:
  - Pop occurs when trace_valid and trace_ready are both 1.
  - trace_* are stable while trace_valid=1 and trace_ready=0.
  - Draining continues in every state, including terminal states.
- Full:
  - A push while full with no simultaneous pop is dropped.
  - overflow is set and stays set until reset.
  - drop_count increments and saturates at 255.
  - Push and pop in the same cycle while full are both accepted (no drop).
  - Push and pop in the same cycle while empty: the push is accepted; trace_valid rises next cycle.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally; full/empty come from the MSB comparison.
- Mid-operation reset: state, FIFO contents, counters and flags are all cleared immediately.

Optional Feature:
- Macro STORE_TRACE_FILTER_EN.
  - Defined: only stores with FILTER_LO <= data_addr_m <= FILTER_HI are pushed.
  - The tohost store is always pushed and always evaluated.
  - Filtered stores never count as drops.
- Undefined: every store is captured; FILTER_LO/FILTER_HI are unused.

Decomposition:
- Package riscv_trace_pkg holds:
  - trace_entry_t, a packed struct {addr, data, time}.
  - mon_state_t, the state enum.
  - Default constants for TOHOST_ADDR and TIMEOUT_CYCLES.
- Sub-module trace_fifo: synchronous FIFO parametrised by DEPTH and the entry type, with push/pop/full/empty.
- The monitor holds the FSM, the counters and the filter logic.

Test Plan:
- Reset, start, then stores (0x10, 0xAA) at cycle 3 and (0x14, 0xBB) at cycle 5, drained with ready=1 -> trace entries (0x10, 0xAA, t=3) then (0x14, 0xBB, t=5); done=0.
- Store (0x100, 1) -> next cycle done=1, pass=1; entry captured; later stores ignored, no new entries.
- Store (0x100, 7) -> done=1, pass=0, timeout=0 (FAIL).
- TIMEOUT_CYCLES=64, no tohost write -> timeout=1 exactly 64 cycles after start.
- DEPTH=4, ready=0, 6 consecutive stores -> 4 entries held, overflow=1, drop_count=2; then a store issued with ready=1 while full -> drop_count stays 2.
- STORE_TRACE_FILTER_EN defined, stores to 0x50 and 0x200, then tohost 0x100=1 -> only 0x50 and 0x100 are captured; drop_count=0; assert reset mid-RUN -> all outputs 0 immediately.
